// File: rtl/max11046_sampler.sv
// max11046_sampler: cycle-counted CONVST/CS/RD sequencer for the MAX11046 ADC.
// It captures NUM_CH parallel words per conversion and emits them as a
// channel-tagged stream, either single-shot (start) or periodic (enable).
module max11046_sampler #(
   parameter int NUM_CH    = 8,
   parameter int DATA_W    = 16,
   parameter int T_CONV    = 4,
   parameter int T_RD_LOW  = 5,
   parameter int T_RD_HIGH = 3,
   parameter int T_GAP     = 7,
   parameter int T_TIMEOUT = 1000,
   parameter int PERIOD    = 2000
) (
   input  logic              i_clock,
   input  logic              i_rst_n,
   input  logic              i_enable,
   input  logic              i_start,
   input  logic [DATA_W-1:0] i_adc_db,
   input  logic              i_adc_eoc_n,
   output logic              o_adc_convst_n,
   output logic              o_adc_cs_n,
   output logic              o_adc_rd_n,
   output logic              o_adc_wr_n,
   output logic [DATA_W-1:0] o_sample_data,
   output logic [2:0]        o_sample_ch,
   output logic              o_sample_valid,
   output logic              o_frame_done,
   output logic              o_timeout_err,
   output logic              o_overrun,
   output logic              o_busy
);

   // one shared phase counter serves every timed state, so size it for the longest
   localparam int C1      = (T_CONV > T_RD_LOW) ? T_CONV : T_RD_LOW;
   localparam int C2      = (C1 > T_RD_HIGH) ? C1 : T_RD_HIGH;
   localparam int C3      = (C2 > T_GAP) ? C2 : T_GAP;
   localparam int CNT_MAX = (C3 > T_TIMEOUT) ? C3 : T_TIMEOUT;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int PER_W   = $clog2(PERIOD + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_CONV, S_WAIT_EOC, S_RD_LOW, S_RD_HIGH, S_GAP
   } state_t;

   state_t             r_state, w_state_nxt;
   logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
   logic [2:0]         r_ch, w_ch_nxt;
   logic [PER_W-1:0]   r_per;
   logic               r_eoc_s1, r_eoc_s2, r_eoc_s3;
   logic               w_eoc_fall, w_capture, w_timeout, w_start_go, w_last_ch;

   assign w_eoc_fall = r_eoc_s3 & ~r_eoc_s2;
   assign w_last_ch  = (r_ch == 3'(NUM_CH - 1));

   // EOC synchronizer plus one history flop for falling-edge detection
   always_ff @(posedge i_clock or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_eoc_s1 <= 1'b1;
         r_eoc_s2 <= 1'b1;
         r_eoc_s3 <= 1'b1;
      end else begin
         r_eoc_s1 <= i_adc_eoc_n;
         r_eoc_s2 <= r_eoc_s1;
         r_eoc_s3 <= r_eoc_s2;
      end
   end

   // state, phase counter and channel counter registers
   always_ff @(posedge i_clock or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_ch    <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_ch    <= w_ch_nxt;
      end
   end

   // next-state logic; each timed state ends when the counter hits its length-1
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt + 1'b1;
      w_ch_nxt    = r_ch;
      w_capture   = 1'b0;
      w_timeout   = 1'b0;
      w_start_go  = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_cnt_nxt = '0;
            w_ch_nxt  = '0;
            if (i_enable) begin
               if (r_per == '0) w_state_nxt = S_CONV;
            end else if (i_start) begin
               w_state_nxt = S_CONV;
               w_start_go  = 1'b1;
            end
         end
         S_CONV: if (r_cnt == CNT_W'(T_CONV - 1)) begin
            w_state_nxt = S_WAIT_EOC;
            w_cnt_nxt   = '0;
         end
         S_WAIT_EOC: begin
            if (w_eoc_fall) begin
               w_state_nxt = S_RD_LOW;
               w_cnt_nxt   = '0;
            end else if (r_cnt == CNT_W'(T_TIMEOUT - 1)) begin
               w_state_nxt = S_GAP;
               w_cnt_nxt   = '0;
               w_timeout   = 1'b1;
            end
         end
         S_RD_LOW: if (r_cnt == CNT_W'(T_RD_LOW - 1)) begin
            w_state_nxt = S_RD_HIGH;
            w_cnt_nxt   = '0;
            w_capture   = 1'b1;
         end
         S_RD_HIGH: if (r_cnt == CNT_W'(T_RD_HIGH - 1)) begin
            w_cnt_nxt = '0;
            if (w_last_ch) begin
               w_state_nxt = S_GAP;
            end else begin
               w_state_nxt = S_RD_LOW;
               w_ch_nxt    = r_ch + 3'd1;
            end
         end
         S_GAP: if (r_cnt == CNT_W'(T_GAP - 1)) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   // period counter: reloads at frame start, parks at 0 when periodic mode is off
   always_ff @(posedge i_clock or negedge i_rst_n) begin
      if (!i_rst_n)                                         r_per <= '0;
      else if (!i_enable)                                   r_per <= '0;
      else if (r_state == S_IDLE && w_state_nxt == S_CONV)  r_per <= PER_W'(PERIOD - 1);
      else if (r_per != '0)                                 r_per <= r_per - 1'b1;
   end

   // registered pin and stream outputs, decoded from the next state so pins
   // change on the same edge as the state
   always_ff @(posedge i_clock or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_adc_convst_n <= 1'b1;
         o_adc_cs_n     <= 1'b1;
         o_adc_rd_n     <= 1'b1;
         o_adc_wr_n     <= 1'b1;
         o_sample_data  <= '0;
         o_sample_ch    <= '0;
         o_sample_valid <= 1'b0;
         o_frame_done   <= 1'b0;
         o_timeout_err  <= 1'b0;
         o_overrun      <= 1'b0;
         o_busy         <= 1'b0;
      end else begin
         o_adc_convst_n <= (w_state_nxt != S_CONV);
         o_adc_cs_n     <= !((w_state_nxt == S_RD_LOW) || (w_state_nxt == S_RD_HIGH));
         o_adc_rd_n     <= (w_state_nxt != S_RD_LOW);
         o_adc_wr_n     <= 1'b1;
         o_busy         <= (w_state_nxt != S_IDLE);
         o_sample_valid <= w_capture;
         o_frame_done   <= w_capture & w_last_ch;
         if (w_capture) begin
            o_sample_data <= i_adc_db;
            o_sample_ch   <= r_ch;
         end
         if (w_timeout)       o_timeout_err <= 1'b1;
         else if (w_start_go) o_timeout_err <= 1'b0;
         if (i_enable && r_per == '0 && r_state != S_IDLE) o_overrun <= 1'b1;
      end
   end

endmodule

// File: tb/tb_max11046_sampler.sv
// Bench for max11046_sampler: three instances (8-ch/timeout 50, 8-ch/period 100,
// 1-ch), one behavioural ADC model attached to whichever instance is selected.
module tb_max11046_sampler;

   typedef struct {
      int dly; int exp_sv; int exp_rd; int exp_rdlow; int exp_cs; int exp_fd; int exp_to;
   } vec_t;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [2:0]      en = '0, st = '0;
   logic [15:0]     db = '0;
   logic            eoc_n = 1'b1;
   logic [2:0]      cv, cs, rd, wr, sv, fd, tmo, ov, bz;
   logic [2:0][15:0] sd;
   logic [2:0][2:0] sc;
   logic [1:0]      sel = '0;

   logic        m_cv, m_cs, m_rd, m_wr, m_sv, m_fd, m_to, m_ov, m_busy;
   logic [15:0] m_data;
   logic [2:0]  m_ch;
   assign m_cv = cv[sel];  assign m_cs = cs[sel];  assign m_rd = rd[sel];
   assign m_wr = wr[sel];  assign m_sv = sv[sel];  assign m_fd = fd[sel];
   assign m_to = tmo[sel]; assign m_ov = ov[sel];  assign m_busy = bz[sel];
   assign m_data = sd[sel]; assign m_ch = sc[sel];

   int eoc_dly = 20;
   int cyc = 0;
   int tests = 0, fails = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   max11046_sampler #(.NUM_CH(8), .T_TIMEOUT(50), .PERIOD(2000)) u_dut0 (
      .i_clock(clk), .i_rst_n(rst_n), .i_enable(en[0]), .i_start(st[0]),
      .i_adc_db(db), .i_adc_eoc_n(eoc_n),
      .o_adc_convst_n(cv[0]), .o_adc_cs_n(cs[0]), .o_adc_rd_n(rd[0]), .o_adc_wr_n(wr[0]),
      .o_sample_data(sd[0]), .o_sample_ch(sc[0]), .o_sample_valid(sv[0]),
      .o_frame_done(fd[0]), .o_timeout_err(tmo[0]), .o_overrun(ov[0]), .o_busy(bz[0]));

   max11046_sampler #(.NUM_CH(8), .T_TIMEOUT(1000), .PERIOD(100)) u_dut1 (
      .i_clock(clk), .i_rst_n(rst_n), .i_enable(en[1]), .i_start(st[1]),
      .i_adc_db(db), .i_adc_eoc_n(eoc_n),
      .o_adc_convst_n(cv[1]), .o_adc_cs_n(cs[1]), .o_adc_rd_n(rd[1]), .o_adc_wr_n(wr[1]),
      .o_sample_data(sd[1]), .o_sample_ch(sc[1]), .o_sample_valid(sv[1]),
      .o_frame_done(fd[1]), .o_timeout_err(tmo[1]), .o_overrun(ov[1]), .o_busy(bz[1]));

   max11046_sampler #(.NUM_CH(1), .T_TIMEOUT(50), .PERIOD(2000)) u_dut2 (
      .i_clock(clk), .i_rst_n(rst_n), .i_enable(en[2]), .i_start(st[2]),
      .i_adc_db(db), .i_adc_eoc_n(eoc_n),
      .o_adc_convst_n(cv[2]), .o_adc_cs_n(cs[2]), .o_adc_rd_n(rd[2]), .o_adc_wr_n(wr[2]),
      .o_sample_data(sd[2]), .o_sample_ch(sc[2]), .o_sample_valid(sv[2]),
      .o_frame_done(fd[2]), .o_timeout_err(tmo[2]), .o_overrun(ov[2]), .o_busy(bz[2]));

   // ADC model: EOC falls eoc_dly clocks after CONVST rises (0 = never);
   // each RD fall presents 16'hA000 + read index on the bus
   int md_cnt = 0, md_rdc = 0;
   logic md_rdp = 1'b1;
   always @(posedge clk) begin
      md_rdp <= m_rd;
      if (!m_cv) begin
         md_cnt <= 0;
         md_rdc <= 0;
         eoc_n  <= 1'b1;
      end else begin
         md_cnt <= md_cnt + 1;
         if (eoc_dly != 0 && md_cnt + 1 == eoc_dly) eoc_n <= 1'b0;
         if (md_rdp && !m_rd) begin
            db     <= 16'hA000 + 16'(md_rdc);
            md_rdc <= md_rdc + 1;
         end
      end
   end

   // monitor: cumulative event counters and timestamps on the falling edge
   logic p_cv = 1'b1, p_rd = 1'b1, p_busy = 1'b0, p_to = 1'b0, rd_seen = 1'b0;
   int cf_cnt = 0, cv_low = 0, cs_low = 0, rd_low = 0, rd_f = 0, sv_cnt = 0, fd_cnt = 0, fd_sv = 0;
   int cr_t = 0, rd_first_t = 0, bf_t = 0, to_t = 0;
   int cf_t[16];
   logic [15:0] log_d[32];
   logic [2:0]  log_c[32];
   always @(negedge clk) begin
      p_cv <= m_cv; p_rd <= m_rd; p_busy <= m_busy; p_to <= m_to;
      if (p_cv && !m_cv) begin
         cf_t[cf_cnt % 16] <= cyc;
         cf_cnt  <= cf_cnt + 1;
         rd_seen <= 1'b0;
      end
      if (!p_cv && m_cv) cr_t <= cyc;
      if (!m_cv) cv_low <= cv_low + 1;
      if (!m_cs) cs_low <= cs_low + 1;
      if (!m_rd) rd_low <= rd_low + 1;
      if (p_rd && !m_rd) begin
         rd_f <= rd_f + 1;
         if (!rd_seen) begin
            rd_first_t <= cyc;
            rd_seen    <= 1'b1;
         end
      end
      if (p_busy && !m_busy) bf_t <= cyc;
      if (!p_to && m_to) to_t <= cyc;
      if (m_sv) begin
         log_d[sv_cnt % 32] <= m_data;
         log_c[sv_cnt % 32] <= m_ch;
         sv_cnt <= sv_cnt + 1;
         if (m_fd) fd_sv <= fd_sv + 1;
      end
      if (m_fd) fd_cnt <= fd_cnt + 1;
   end

   task automatic chk(input string nm, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
      end
   endtask

   function automatic int probe(input int w);
      case (w)
         0:       return cf_cnt;
         1:       return rd_f;
         default: return int'(!m_busy);
      endcase
   endfunction

   // bounded wait on a monitor quantity; an expired bound counts as a failure
   task automatic wait_until(input int w, input int target, input int maxc, input string nm,
                             input int settle);
      int n = 0;
      while (probe(w) < target && n < maxc) begin
         @(negedge clk);
         n++;
      end
      if (probe(w) < target) begin
         tests++;
         fails++;
         $display("FAIL %s: wait expired after %0d cycles", nm, n);
      end
      repeat (settle) @(negedge clk);
   endtask

   task automatic run_start();
      @(posedge clk); #1 st[sel] = 1'b1;
      @(posedge clk); #1 st[sel] = 1'b0;
   endtask

   task automatic check_samples(input int base, input int n);
      for (int i = 0; i < n; i++) begin
         chk("sample_ch", int'(log_c[(base + i) % 32]), i);
         chk("sample_data", int'(log_d[(base + i) % 32]), 'hA000 + i);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not reach the end");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tv[5];
      int b_cf, b_sv, b_rd, b_cs, b_cv, b_rl, b_fd, b_fs;
      tv[0] = '{20, 8, 8, 40, 64, 1, 0};
      tv[1] = '{ 0, 0, 0,  0,  0, 0, 1};
      tv[2] = '{ 3, 8, 8, 40, 64, 1, 0};
      tv[3] = '{60, 0, 0,  0,  0, 0, 1};
      tv[4] = '{45, 8, 8, 40, 64, 1, 0};

      // reset values, during and after reset, on every instance
      #12;
      for (int k = 0; k < 3; k++) begin
         sel = 2'(k);
         #1;
         chk("rst_ctl", int'({m_cv, m_cs, m_rd, m_wr, m_sv, m_fd, m_to, m_ov, m_busy}), 'h1E0);
         chk("rst_data", int'({m_ch, m_data}), 0);
      end
      @(posedge clk); #1 rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      sel = 2'd0;
      chk("post_rst_ctl", int'({m_cv, m_cs, m_rd, m_wr, m_sv, m_fd, m_to, m_ov, m_busy}), 'h1E0);

      // single-shot frames, normal and timeout
      for (int v = 0; v < 5; v++) begin
         eoc_dly = tv[v].dly;
         b_cf = cf_cnt; b_sv = sv_cnt; b_rd = rd_f; b_cs = cs_low;
         b_cv = cv_low; b_rl = rd_low; b_fd = fd_cnt; b_fs = fd_sv;
         run_start();
         chk("timeout_cleared_by_start", int'(m_to), 0);
         wait_until(2, 1, 400, "frame_idle", 3);
         chk("convst_falls", cf_cnt - b_cf, 1);
         chk("convst_low_clks", cv_low - b_cv, 4);
         chk("sample_count", sv_cnt - b_sv, tv[v].exp_sv);
         chk("rd_falls", rd_f - b_rd, tv[v].exp_rd);
         chk("rd_low_clks", rd_low - b_rl, tv[v].exp_rdlow);
         chk("cs_low_clks", cs_low - b_cs, tv[v].exp_cs);
         chk("frame_done_count", fd_cnt - b_fd, tv[v].exp_fd);
         chk("frame_done_with_last", fd_sv - b_fs, tv[v].exp_fd);
         chk("timeout_flag", int'(m_to), tv[v].exp_to);
         if (tv[v].exp_sv > 0) begin
            check_samples(b_sv, tv[v].exp_sv);
            chk("rd_to_idle_clks", bf_t - rd_first_t, 71);
         end
         if (tv[v].exp_to != 0) chk("timeout_latency", to_t - cr_t, 50);
      end

      // continuous mode, 5 frames exactly PERIOD apart
      eoc_dly = 20;
      b_cf = cf_cnt;
      @(posedge clk); #1 en[0] = 1'b1;
      wait_until(0, b_cf + 5, 12000, "continuous_frames", 0);
      @(posedge clk); #1 en[0] = 1'b0;
      wait_until(2, 1, 400, "continuous_idle", 3);
      for (int i = 0; i < 4; i++)
         chk("period_spacing", cf_t[(b_cf + i + 1) % 16] - cf_t[(b_cf + i) % 16], 2000);
      chk("no_overrun", int'(m_ov), 0);

      // overrun: PERIOD=100 against a ~118-clock frame
      sel = 2'd1;
      eoc_dly = 40;
      b_cf = cf_cnt;
      @(posedge clk); #1 en[1] = 1'b1;
      wait_until(0, b_cf + 2, 600, "overrun_frames", 2);
      @(posedge clk); #1 en[1] = 1'b0;
      chk("overrun_flag", int'(m_ov), 1);
      chk("restart_after_idle", cf_t[(b_cf + 1) % 16] - bf_t, 1);
      wait_until(2, 1, 400, "overrun_idle", 3);

      // reset during channel 3 RD_LOW
      sel = 2'd0;
      eoc_dly = 20;
      b_sv = sv_cnt; b_rd = rd_f;
      run_start();
      wait_until(1, b_rd + 4, 300, "reach_ch3", 0);
      #1 rst_n = 1'b0;
      #1 chk("async_reset_pins", int'({m_cv, m_cs, m_rd, m_busy}), 'hE);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (5) @(negedge clk);
      chk("no_partial_sample", sv_cnt - b_sv, 3);
      b_sv = sv_cnt;
      run_start();
      wait_until(2, 1, 400, "post_reset_idle", 3);
      chk("post_reset_samples", sv_cnt - b_sv, 8);
      check_samples(b_sv, 8);

      // NUM_CH=1 with start held high through most of the frame
      sel = 2'd2;
      eoc_dly = 20;
      b_cf = cf_cnt; b_sv = sv_cnt; b_fd = fd_cnt; b_fs = fd_sv;
      @(posedge clk); #1 st[2] = 1'b1;
      repeat (30) @(posedge clk);
      #1 st[2] = 1'b0;
      wait_until(2, 1, 400, "single_ch_idle", 3);
      repeat (20) @(negedge clk);
      chk("single_ch_frames", cf_cnt - b_cf, 1);
      chk("single_ch_samples", sv_cnt - b_sv, 1);
      chk("single_ch_done", fd_cnt - b_fd, 1);
      chk("single_ch_done_with_sv", fd_sv - b_fs, 1);
      chk("single_ch_rd_to_idle", bf_t - rd_first_t, 15);
      check_samples(b_sv, 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/max11046_sampler.md
# max11046_sampler

Parametrised, synthesizable successor to the MAX11046 control logic. A fully cycle-counted state machine drives the ADC conversion and read handshake, CONVST/CS/RD/WR, for a configurable number of channels. It captures each parallel data word and presents it as a channel-tagged stream, in single-shot or free-running periodic mode. It sits between the ADC pins in `top` and the downstream force-processing logic.

## Interface
- `NUM_CH`, 8, channels read per conversion (1..8).
- `DATA_W`, 16, ADC data bus width.
- `T_CONV`, 4, CONVST low width in clocks (≥1).
- `T_RD_LOW`, 5, RD low width in clocks (≥2).
- `T_RD_HIGH`, 3, RD high time between reads in clocks (≥1).
- `T_GAP`, 7, CS high recovery after the last read in clocks (≥1).
- `T_TIMEOUT`, 1000, max clocks from CONVST rise to EOC fall.
- `PERIOD`, 2000, clocks between CONVST falls in continuous mode.
- `clock` in 1: system clock, the rising edge is active.
- `rst_n` in 1: asynchronous, active-low reset.
- `enable` in 1: continuous mode. While high, a frame starts every `PERIOD` clocks.
- `start` in 1: single-frame request. Sampled in IDLE only.
- `adc_db` in `DATA_W`: ADC parallel data, asynchronous to `clock`.
- `adc_eoc_n` in 1: ADC end-of-conversion, active low, asynchronous.
- `adc_convst_n` out 1: conversion start, active low.
- `adc_cs_n` out 1: chip select, active low.
- `adc_rd_n` out 1: read strobe, active low.
- `adc_wr_n` out 1: write strobe. Held high; no configuration writes.
- `sample_data` out `DATA_W`: captured word.
- `sample_ch` out 3: channel index 0..`NUM_CH`-1.
- `sample_valid` out 1: one-clock strobe qualifying `sample_data` and `sample_ch`.
- `frame_done` out 1: one-clock strobe after the last channel of a frame.
- `timeout_err` out 1: sticky flag. Cleared by reset or by a new `start`.
- `overrun` out 1: sticky flag. Set when a frame exceeds `PERIOD`; cleared by reset.
- `busy` out 1: high in any state other than IDLE.

## Operation
- `adc_eoc_n` passes through a 2-flop synchronizer, then falling-edge detection produces `eoc_fall`.
- States: IDLE → CONV → WAIT_EOC → RD_LOW → RD_HIGH → (RD_LOW … ) → GAP → IDLE.
- **IDLE**
  - All ADC outputs are high.
  - Leave on `start` or `enable`: if `enable` is high, wait for the period counter to reach 0; if `enable` is low and `start` is high, leave immediately.
- **CONV**: `adc_convst_n` is low for `T_CONV` clocks, then goes high.
- **WAIT_EOC**
  - On `eoc_fall`, go to RD_LOW.
  - If `T_TIMEOUT` clocks elapse first, set `timeout_err`, drive no samples, and go to GAP.
- **RD_LOW**
  - `adc_cs_n` is low from RD_LOW entry until GAP entry.
  - `adc_rd_n` is low for `T_RD_LOW` clocks.
  - On the last clock of RD_LOW, `adc_db` is registered.
- **RD_HIGH**
  - `adc_rd_n` is high for `T_RD_HIGH` clocks.
  - The channel counter increments.
  - After channel `NUM_CH`-1, go to GAP instead of RD_LOW.
- **GAP**: CS is high for `T_GAP` clocks, then go to IDLE.
- **Sample output**
  - `sample_valid` pulses on the clock after data capture, i.e. the first RD_HIGH clock.
  - `sample_ch` equals the channel counter value used for that read.
  - `frame_done` pulses together with the last `sample_valid`.
- **Period counter**
  - Free-running while `enable` is high, reloaded to `PERIOD`-1 at each CONV entry.
  - If it reaches 0 while `busy` is high, set `overrun`; the next frame then starts on IDLE entry.
  - When `enable` is low, it is held at 0.
- `start` while `busy` is high is ignored; requests are not queued.

## Timing
- **Reset values**
  - `adc_convst_n`, `adc_cs_n`, `adc_rd_n`, `adc_wr_n` = 1.
  - `sample_data` = 0, `sample_ch` = 0.
  - `sample_valid`, `frame_done`, `timeout_err`, `overrun`, `busy` = 0.
  - State = IDLE, all counters = 0.
- **Reset mid-operation**: the outputs above are applied asynchronously within the same cycle; no partial sample is emitted.
- **Latency**
  - `start` to `adc_convst_n` low: 1 clock.
  - `eoc_fall` lags the pin by 2–3 clocks.
  - `eoc_fall` to `adc_rd_n` low: 1 clock.
- **Read cycle**: `T_RD_LOW`+`T_RD_HIGH` clocks per channel.
- **Frame length after EOC**: `NUM_CH`×(`T_RD_LOW`+`T_RD_HIGH`)+`T_GAP` clocks.
- All outputs are registered, with no combinational path from inputs to outputs.
- An EOC fall outside WAIT_EOC is ignored.

## Test plan
- **Single frame**
  - Stimulus: `NUM_CH`=8; model asserts EOC 20 clocks after CONVST rises; DB = 16'hA000+ch.
  - Required: 8 `sample_valid` pulses carrying 16'hA000..16'hA007 with ch 0..7; `frame_done` on the 8th; RD goes low exactly 8 times; `busy` drops after GAP.
- **Timeout**
  - Stimulus: EOC is never asserted; `T_TIMEOUT`=50.
  - Required: `timeout_err` set 50 clocks after CONVST rises; no `sample_valid`; return to IDLE; the next `start` clears the flag.
- **Continuous mode**
  - Stimulus: `enable`=1, `PERIOD`=2000.
  - Required: CONVST falls exactly 2000 clocks apart over 5 frames; `overrun` stays 0.
- **Overrun**
  - Stimulus: `PERIOD`=100 with a frame longer than 100 clocks.
  - Required: `overrun`=1; the next frame starts immediately on IDLE entry.
- **Reset mid-read**
  - Stimulus: `rst_n` pulled low during channel 3 RD_LOW.
  - Required: CS/RD/CONVST high in the same cycle; no `sample_valid`; a clean frame after release.
- **Edge cases**
  - Stimulus: `NUM_CH`=1; `start` held high while busy.
  - Required: one sample per frame with `frame_done` on the same clock; no extra frames are queued.
